dig_ota_bank: RTL

Multi-channel clocked digital OTA/comparator bank; next generation of the single-channel asynchronous digital OTA used in the TinyTapeout top. Each of `CHANNELS` channels synchronises its differential pair (`vip`/`vin`), makes a three-way decision (up, down, hold) and drives a registered output. The output is either direct or passes through a saturating up/down integrator with rail hysteresis. It sits between `ui_in` and `uo_out` in the top-level wrapper.

---
 rtl/dig_ota_pkg.sv | 37 +++
 rtl/dig_ota_chan.sv | 130 +++++++++++++
 rtl/dig_ota_bank.sv | 82 ++++++++
 3 files changed

// File: rtl/dig_ota_pkg.sv
// -----------------------------------------------------------------------------
// dig_ota_pkg
// Shared types and constants for the digital OTA / comparator bank.
//   ota_dec_t  : three-way per-channel decision (HOLD / UP / DOWN)
//   ota_mode_t : output mode shared by all channels (DIRECT / INTEG)
//   decide()   : maps a synchronised differential pair onto a decision
// -----------------------------------------------------------------------------
package dig_ota_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ota_dec_t;

    typedef enum logic {
        DIRECT = 1'b0,
        INTEG  = 1'b1
    } ota_mode_t;

    localparam int CHANNELS_MAX = 8;
    localparam int CNT_W_MIN    = 2;
    localparam int CNT_W_MAX    = 6;

    // Equal inputs (both high or both low) carry no information -> HOLD.
    function automatic ota_dec_t decide(input logic p, input logic n);
        ota_dec_t d;
        d = HOLD;
        if (p && !n) begin
            d = UP;
        end else if (!p && n) begin
            d = DOWN;
        end
        return d;
    endfunction

endpackage

// File: rtl/dig_ota_chan.sv
// -----------------------------------------------------------------------------
// dig_ota_chan
// One comparator channel: 2-flop synchroniser on each input, three-way
// decision, saturating integrator with rail hysteresis, registered output and
// (with DIG_OTA_BANK_IRQ_EN defined) a sticky change flag.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst_n    in   synchronous active-low reset
//   ena      in   enable; 0 freezes cnt/out (synchroniser keeps running)
//   mode     in   requested mode (0 direct, 1 integrating)
//   mode_q   in   registered mode from the top; differs from mode on a switch
//   vip/vin  in   asynchronous differential inputs
//   out      out  registered channel output
//   irq_clr  in   clears toggled           (DIG_OTA_BANK_IRQ_EN only)
//   toggled  out  sticky out-change flag   (DIG_OTA_BANK_IRQ_EN only)
// -----------------------------------------------------------------------------
module dig_ota_chan
    import dig_ota_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic mode,
    input  logic mode_q,
    input  logic vip,
    input  logic vin,
    output logic out
`ifdef DIG_OTA_BANK_IRQ_EN
    ,
    input  logic irq_clr,
    output logic toggled
`endif
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic             p_p0;
    logic             n_p0;
    logic             p_s;
    logic             n_s;
    ota_dec_t         dec;
    ota_mode_t        mode_e;
    logic             mode_sw;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             out_next;

    // Saturating step helpers: the integrator never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // ---- stage p0 -> p_s : two-flop synchroniser, runs regardless of ena ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_p0 <= 1'b0;
            n_p0 <= 1'b0;
            p_s  <= 1'b0;
            n_s  <= 1'b0;
        end else begin
            p_p0 <= vip;
            n_p0 <= vin;
            p_s  <= p_p0;
            n_s  <= n_p0;
        end
    end

    assign dec     = decide(p_s, n_s);
    assign mode_e  = ota_mode_t'(mode);
    assign mode_sw = (mode != mode_q);

    // ---- decision -> cnt/out : next-state of integrator and output ----
    always_comb begin
        cnt_next = cnt;
        out_next = out;
        if (mode_sw) begin
            // Align the counter with the current rail so the new mode starts
            // without a glitch; the decision on this edge is dropped.
            cnt_next = out ? MAX : '0;
        end else if (mode_e == DIRECT) begin
            case (dec)
                UP:      out_next = 1'b1;
                DOWN:    out_next = 1'b0;
                default: out_next = out;
            endcase
            cnt_next = out_next ? MAX : '0;
        end else begin
            case (dec)
                UP:      cnt_next = sat_inc(cnt);
                DOWN:    cnt_next = sat_dec(cnt);
                default: cnt_next = cnt;
            endcase
            // Output only moves at the rails: hysteresis spans the full range.
            if (cnt_next == MAX) begin
                out_next = 1'b1;
            end else if (cnt_next == '0) begin
                out_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (ena) begin
            cnt <= cnt_next;
            out <= out_next;
        end
    end

`ifdef DIG_OTA_BANK_IRQ_EN
    // A new change wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggled <= 1'b0;
        end else begin
            toggled <= (ena && (out_next != out)) || (toggled && !irq_clr);
        end
    end
`endif

endmodule

// File: rtl/dig_ota_bank.sv
// -----------------------------------------------------------------------------
// dig_ota_bank
// Multi-channel clocked digital OTA / comparator bank. Each channel syncs its
// differential pair, decides up/down/hold and drives a registered output,
// either directly or through a saturating integrator with rail hysteresis.
//
// Optional feature macro: DIG_OTA_BANK_IRQ_EN adds per-channel sticky change
// flags (toggled), their OR (irq) and a clear input (irq_clr). Without it the
// core is cycle-identical and those ports do not exist.
//
// Parameters:
//   CHANNELS  number of channels (1..8)
//   CNT_W     integrator width (2..6), MAX = 2**CNT_W - 1
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   ena      in   global enable (0 freezes cnt/out/mode_q)
//   mode     in   0 direct, 1 integrating (all channels)
//   vip/vin  in   [CHANNELS] asynchronous differential inputs
//   out      out  [CHANNELS] registered outputs
//   toggled  out  [CHANNELS] sticky change flags      (macro only)
//   irq      out  OR of toggled                       (macro only)
//   irq_clr  in   clears all toggled bits             (macro only)
// -----------------------------------------------------------------------------
module dig_ota_bank
    import dig_ota_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                mode,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    output logic [CHANNELS-1:0] out
`ifdef DIG_OTA_BANK_IRQ_EN
    ,
    output logic [CHANNELS-1:0] toggled,
    output logic                irq,
    input  logic                irq_clr
`endif
);

    logic mode_q;

    // Registered mode; a mismatch with mode marks the switch edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (ena) begin
            mode_q <= mode;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        dig_ota_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .mode    (mode),
            .mode_q  (mode_q),
            .vip     (vip[i]),
            .vin     (vin[i]),
            .out     (out[i])
`ifdef DIG_OTA_BANK_IRQ_EN
            ,
            .irq_clr (irq_clr),
            .toggled (toggled[i])
`endif
        );
    end

`ifdef DIG_OTA_BANK_IRQ_EN
    assign irq = |toggled;
`endif

endmodule
